// File: rtl/mem_arbiter_if.sv
// Memory-port bundle shared by the arbiter, CPU datapath, I/O requester and Memory.
// slave = arbiter side; master = environment (CPU, requester, Memory) side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_CPU_HALTED;
   logic              o_IOPAUSE;
   logic [ADDR_W-1:0] i_CPU_RADDR;
   logic [ADDR_W-1:0] i_CPU_WADDR;
   logic [DATA_W-1:0] i_CPU_WDATA;
   logic              i_CPU_WRITE;
   logic              i_IO_REQ;
   logic              i_IO_WRITE;
   logic [ADDR_W-1:0] i_IO_ADDR;
   logic [DATA_W-1:0] i_IO_WDATA;
   logic              o_IO_GNT;
   logic              o_IO_ACK;
   logic [DATA_W-1:0] o_IO_RDATA;
   logic [ADDR_W-1:0] o_MEM_RADDR;
   logic [ADDR_W-1:0] o_MEM_WADDR;
   logic [DATA_W-1:0] o_MEM_WDATA;
   logic              o_MEM_WRITE;
   logic [DATA_W-1:0] i_MEM_RDATA;
   logic              o_OWNER;

   modport slave (
      input  i_CPU_HALTED, i_CPU_RADDR, i_CPU_WADDR, i_CPU_WDATA, i_CPU_WRITE,
      input  i_IO_REQ, i_IO_WRITE, i_IO_ADDR, i_IO_WDATA, i_MEM_RDATA,
      output o_IOPAUSE, o_IO_GNT, o_IO_ACK, o_IO_RDATA,
      output o_MEM_RADDR, o_MEM_WADDR, o_MEM_WDATA, o_MEM_WRITE, o_OWNER
   );

   modport master (
      output i_CPU_HALTED, i_CPU_RADDR, i_CPU_WADDR, i_CPU_WDATA, i_CPU_WRITE,
      output i_IO_REQ, i_IO_WRITE, i_IO_ADDR, i_IO_WDATA, i_MEM_RDATA,
      input  o_IOPAUSE, o_IO_GNT, o_IO_ACK, o_IO_RDATA,
      input  o_MEM_RADDR, o_MEM_WADDR, o_MEM_WDATA, o_MEM_WRITE, o_OWNER
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the memory port between CPU and one I/O requester; burst cap only with MEM_ARB_BURST_LIMIT_EN.
// Latency: grant 2 clocks after request if CPU halted, ack 1 clock after each transfer; requester waits on o_IO_GNT.
module mem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 8,
   parameter int CPU_GUARD = 4
) (
   input logic          i_CLOCK,
   input logic          i_RESETn,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_CPU        = 2'd0,
      ST_PAUSE_WAIT = 2'd1,
      ST_IO         = 2'd2,
      ST_RELEASE    = 2'd3
   } state_t;

   localparam logic [7:0] GUARD_LD = CPU_GUARD[7:0];

   if (ADDR_W < 1 || DATA_W < 1 || MAX_BURST < 1 || MAX_BURST > 255 ||
       CPU_GUARD < 0 || CPU_GUARD > 255) begin : g_bad_param
      $error("mem_arbiter: parameter out of range");
   end

   state_t            state, state_nxt;
   logic [7:0]        guard_cnt, guard_nxt;
   logic              pause_q, gnt_q, owner_q, ack_q;
   logic [DATA_W-1:0] rdata_q;
   logic              xfer;
   logic              burst_done;

   assign xfer = (state == ST_IO) && bus.i_IO_REQ;

`ifdef MEM_ARB_BURST_LIMIT_EN
   localparam logic [7:0] BURST_LIM = MAX_BURST[7:0];
   logic [7:0] burst_cnt;

   // Counter is cleared whenever outside IO, so every grant starts from zero.
   always_ff @(posedge i_CLOCK or negedge i_RESETn) begin
      if (!i_RESETn)            burst_cnt <= 8'd0;
      else if (state != ST_IO)  burst_cnt <= 8'd0;
      else if (xfer)            burst_cnt <= burst_cnt + 8'd1;
   end

   assign burst_done = xfer && ((burst_cnt + 8'd1) == BURST_LIM);
`else
   assign burst_done = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      guard_nxt = guard_cnt;
      case (state)
         ST_CPU: begin
            if (guard_cnt != 8'd0)
               guard_nxt = guard_cnt - 8'd1;
            if (bus.i_IO_REQ && guard_cnt == 8'd0)
               state_nxt = ST_PAUSE_WAIT;
         end
         ST_PAUSE_WAIT: begin
            if (!bus.i_IO_REQ)
               state_nxt = ST_RELEASE;
            else if (bus.i_CPU_HALTED)
               state_nxt = ST_IO;
         end
         ST_IO: begin
            if (!bus.i_IO_REQ || burst_done)
               state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            guard_nxt = GUARD_LD;
            state_nxt = ST_CPU;
         end
         default: state_nxt = ST_CPU;
      endcase
   end

   // Pause/grant/owner are flopped from the next state so they line up with the state register.
   always_ff @(posedge i_CLOCK or negedge i_RESETn) begin
      if (!i_RESETn) begin
         state     <= ST_CPU;
         guard_cnt <= 8'd0;
         pause_q   <= 1'b0;
         gnt_q     <= 1'b0;
         owner_q   <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state     <= state_nxt;
         guard_cnt <= guard_nxt;
         pause_q   <= (state_nxt != ST_CPU);
         gnt_q     <= (state_nxt == ST_IO);
         owner_q   <= (state_nxt == ST_IO);
         ack_q     <= xfer;
         if (xfer && !bus.i_IO_WRITE)
            rdata_q <= bus.i_MEM_RDATA;
      end
   end

   always_comb begin
      bus.o_MEM_RADDR = bus.i_CPU_RADDR;
      bus.o_MEM_WADDR = bus.i_CPU_WADDR;
      bus.o_MEM_WDATA = bus.i_CPU_WDATA;
      bus.o_MEM_WRITE = bus.i_CPU_WRITE;
      case (state)
         ST_IO: begin
            bus.o_MEM_RADDR = bus.i_IO_ADDR;
            bus.o_MEM_WADDR = bus.i_IO_ADDR;
            bus.o_MEM_WDATA = bus.i_IO_WDATA;
            // Idle IO cycles must not write memory.
            bus.o_MEM_WRITE = bus.i_IO_WRITE && bus.i_IO_REQ;
         end
         ST_RELEASE: bus.o_MEM_WRITE = 1'b0;
         default: ;
      endcase
   end

   assign bus.o_IOPAUSE  = pause_q;
   assign bus.o_IO_GNT   = gnt_q;
   assign bus.o_OWNER    = owner_q;
   assign bus.o_IO_ACK   = ack_q;
   assign bus.o_IO_RDATA = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level behavioural model.
module tb_mem_arbiter;
   localparam int ADDR_W = 16, DATA_W = 16, MAX_BURST = 8, CPU_GUARD = 4;
`ifdef MEM_ARB_BURST_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CPU_GUARD(CPU_GUARD))
      dut (.i_CLOCK(clk), .i_RESETn(rst_n), .bus(bus));

   // Memory stub: read data is a fixed function of the read address.
   assign bus.i_MEM_RDATA = 16'hA000 + bus.o_MEM_RADDR;

   int checks = 0;
   int failures = 0;

   // Model: paused / granted / releasing flags, transfers this grant, guard clocks left.
   bit          m_pause, m_gnt, m_rel, m_ack;
   int          m_guard, m_xfers;
   logic [15:0] m_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pause = 0; m_gnt = 0; m_rel = 0; m_ack = 0;
      m_guard = 0; m_xfers = 0; m_rdata = 16'h0;
   endtask

   task automatic compare();
      logic [15:0] ra, wa, wd;
      logic        we;
      if (m_gnt) begin
         ra = bus.i_IO_ADDR; wa = bus.i_IO_ADDR; wd = bus.i_IO_WDATA;
         we = bus.i_IO_WRITE & bus.i_IO_REQ;
      end else begin
         ra = bus.i_CPU_RADDR; wa = bus.i_CPU_WADDR; wd = bus.i_CPU_WDATA;
         we = m_rel ? 1'b0 : bus.i_CPU_WRITE;
      end
      chk("iopause", bus.o_IOPAUSE, m_pause);
      chk("io_gnt", bus.o_IO_GNT, m_gnt);
      chk("owner", bus.o_OWNER, m_gnt);
      chk("io_ack", bus.o_IO_ACK, m_ack);
      chk("io_rdata", bus.o_IO_RDATA, m_rdata);
      chk("mem_raddr", bus.o_MEM_RADDR, ra);
      chk("mem_waddr", bus.o_MEM_WADDR, wa);
      chk("mem_wdata", bus.o_MEM_WDATA, wd);
      chk("mem_write", bus.o_MEM_WRITE, we);
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_advance();
      bit req;
      req = bus.i_IO_REQ;
      m_ack = m_gnt && req;
      if (m_ack && !bus.i_IO_WRITE)
         m_rdata = 16'hA000 + bus.i_IO_ADDR;
      if (m_rel) begin
         m_rel = 0; m_pause = 0; m_guard = CPU_GUARD;
      end else if (m_gnt) begin
         if (req) m_xfers++;
         if (!req || (LIMIT && m_xfers == MAX_BURST)) begin
            m_gnt = 0; m_rel = 1;
         end
      end else if (m_pause) begin
         if (!req) m_rel = 1;
         else if (bus.i_CPU_HALTED) begin
            m_gnt = 1; m_xfers = 0;
         end
      end else begin
         if (req && m_guard == 0) m_pause = 1;
         else if (m_guard > 0) m_guard--;
      end
   endtask

   // Called right after a falling edge with this cycle's inputs applied.
   task automatic step();
      #1;
      compare();
      model_advance();
      @(negedge clk);
   endtask

   task automatic wait_gnt(input string name);
      for (int i = 0; i < 30; i++) begin
         if (bus.o_IO_GNT) break;
         step();
      end
      chk(name, bus.o_IO_GNT, 1'b1);
   endtask

   task automatic wait_pause(input string name);
      for (int i = 0; i < 30; i++) begin
         if (bus.o_IOPAUSE) break;
         step();
      end
      chk(name, bus.o_IOPAUSE, 1'b1);
   endtask

   task automatic settle();
      bus.i_IO_REQ = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!bus.i_IO_REQ && !bus.o_IOPAUSE) break;
         step();
      end
      repeat (CPU_GUARD + 1) step();
   endtask

   task automatic rand_cpu();
      bus.i_CPU_RADDR = 16'($urandom);
      bus.i_CPU_WADDR = 16'($urandom);
      bus.i_CPU_WDATA = 16'($urandom);
      bus.i_CPU_WRITE = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] acks[$];
      int          n;

      model_reset();
      rand_cpu();
      bus.i_IO_REQ = 1'b1; bus.i_CPU_HALTED = 1'b1;
      bus.i_IO_WRITE = 1'b0; bus.i_IO_ADDR = 16'h0; bus.i_IO_WDATA = 16'h0;
      #3;
      compare();
      @(negedge clk);
      rst_n = 1'b1;

      // Request pending out of reset with CPU halted: pause at cycle 1, grant at cycle 2.
      step();
      chk("startup_pause_c1", bus.o_IOPAUSE, 1'b1);
      chk("startup_gnt_c1", bus.o_IO_GNT, 1'b0);
      step();
      chk("startup_gnt_c2", bus.o_IO_GNT, 1'b1);
      bus.i_IO_REQ = 1'b0;
      settle();

      // Read burst of three.
      bus.i_IO_REQ = 1'b1; bus.i_IO_WRITE = 1'b0; bus.i_IO_ADDR = 16'h0100;
      wait_gnt("burst3_gnt");
      for (int i = 0; i < 3; i++) begin
         bus.i_IO_ADDR = 16'h0100 + 16'(i);
         rand_cpu();
         step();
         if (bus.o_IO_ACK) acks.push_back(bus.o_IO_RDATA);
      end
      bus.i_IO_REQ = 1'b0;
      step();
      chk("burst3_release_gnt", bus.o_IO_GNT, 1'b0);
      chk("burst3_release_pause", bus.o_IOPAUSE, 1'b1);
      step();
      chk("burst3_pause_low", bus.o_IOPAUSE, 1'b0);
      chk("burst3_ack_count", acks.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("burst3_rdata", (i < acks.size()) ? acks[i] : 16'hxxxx, 16'hA100 + 16'(i));
      settle();

      // Continuous request.
      bus.i_IO_REQ = 1'b1; bus.i_CPU_HALTED = 1'b1;
      wait_gnt("cont_gnt");
      n = 0;
      if (LIMIT) begin
         while (bus.o_IO_GNT && n < 30) begin
            bus.i_IO_ADDR = 16'($urandom);
            step();
            n++;
         end
         chk("cont_burst_len", n, MAX_BURST);
         step();
         wait_pause("cont_repause");
      end else begin
         for (int i = 0; i < 20; i++) begin
            bus.i_IO_ADDR = 16'($urandom);
            step();
            if (bus.o_IO_ACK) n++;
         end
         chk("cont_no_release", bus.o_IO_GNT, 1'b1);
         chk("cont_ack_count", n, 20);
      end
      settle();

      // Pause held while CPU not halted; CPU writes still pass through.
      bus.i_IO_REQ = 1'b1; bus.i_CPU_HALTED = 1'b0;
      wait_pause("halt_wait_pause");
      for (int i = 0; i < 5; i++) begin
         rand_cpu();
         bus.i_CPU_WRITE = 1'b1;
         step();
         chk("halt_wait_no_gnt", bus.o_IO_GNT, 1'b0);
      end
      bus.i_CPU_HALTED = 1'b1;
      step();
      chk("grant_after_halt", bus.o_IO_GNT, 1'b1);
      settle();

      // Request withdrawn during pause wait.
      bus.i_IO_REQ = 1'b1; bus.i_CPU_HALTED = 1'b0;
      wait_pause("drop_pause");
      bus.i_IO_REQ = 1'b0;
      step();
      chk("drop_release_gnt", bus.o_IO_GNT, 1'b0);
      chk("drop_release_ack", bus.o_IO_ACK, 1'b0);
      chk("drop_release_pause", bus.o_IOPAUSE, 1'b1);
      step();
      chk("drop_pause_low", bus.o_IOPAUSE, 1'b0);
      settle();

      // Asynchronous reset in the middle of a write burst.
      bus.i_IO_REQ = 1'b1; bus.i_CPU_HALTED = 1'b1; bus.i_IO_WRITE = 1'b1;
      wait_gnt("rst_burst_gnt");
      step();
      bus.i_CPU_WRITE = 1'b0;
      step();
      chk("rst_pre_write", bus.o_MEM_WRITE, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_pause", bus.o_IOPAUSE, 1'b0);
      chk("rst_async_gnt", bus.o_IO_GNT, 1'b0);
      chk("rst_async_ack", bus.o_IO_ACK, 1'b0);
      chk("rst_async_write", bus.o_MEM_WRITE, 1'b0);
      model_reset();
      bus.i_IO_REQ = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         rand_cpu();
         bus.i_IO_REQ     = ($urandom_range(0, 9) < 7);
         bus.i_CPU_HALTED = ($urandom_range(0, 3) != 0);
         bus.i_IO_WRITE   = 1'($urandom);
         bus.i_IO_ADDR    = 16'($urandom);
         bus.i_IO_WDATA   = 16'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single memory port between the CPU datapath and one external I/O/DMA requester. The block sits between the Memory instance and its two masters. It stalls the CPU's X/Y/Z cycle sequencer through the I/O pause input, grants the port to the requester for a bounded burst, then hands the port back. While the CPU owns the port, all CPU memory signals pass straight through unchanged.

## Interface
- ADDR_W, 16, address width of all memory addresses
- DATA_W, 16, memory data width
- MAX_BURST, 8, maximum I/O transfers per grant (legal range 1..255)
- CPU_GUARD, 4, clocks the CPU keeps the port after a release before a new pause may be raised (0 = none)

Ports:
- i_CLOCK  in  1  single system clock; all state changes on its rising edge
- i_RESETn  in  1  reset; asynchronous, active-low
- i_CPU_HALTED  in  1  sequencer is stopped at an instruction boundary (level)
- o_IOPAUSE  out  1  stall request to the cycle sequencer
- i_CPU_RADDR / i_CPU_WADDR  in  ADDR_W  CPU read/write addresses
- i_CPU_WDATA  in  DATA_W  CPU write data
- i_CPU_WRITE  in  1  CPU write enable
- i_IO_REQ  in  1  requester wants a transfer this cycle (level)
- i_IO_WRITE  in  1  1 = write, 0 = read
- i_IO_ADDR  in  ADDR_W  transfer address
- i_IO_WDATA  in  DATA_W  write data
- o_IO_GNT  out  1  requester owns the port this cycle
- o_IO_ACK  out  1  one-cycle pulse: previous granted transfer completed
- o_IO_RDATA  out  DATA_W  read data, valid with o_IO_ACK
- o_MEM_RADDR / o_MEM_WADDR  out  ADDR_W  to Memory
- o_MEM_WDATA  out  DATA_W  to Memory
- o_MEM_WRITE  out  1  to Memory
- i_MEM_RDATA  in  DATA_W  from Memory
- o_OWNER  out  1  0 = CPU, 1 = I/O (registered)

## Operation
- States are CPU, PAUSE_WAIT, IO and RELEASE. Reset enters CPU.
- **CPU**
  - Memory outputs are a combinational pass-through of the CPU signals.
  - If i_IO_REQ=1 and the guard counter is 0, go to PAUSE_WAIT.
- **PAUSE_WAIT**
  - o_IOPAUSE=1 and the CPU pass-through continues.
  - If i_IO_REQ drops, go to RELEASE.
  - Otherwise, when i_CPU_HALTED=1, go to IO and clear the burst counter.
- **IO**
  - o_IOPAUSE=1, o_IO_GNT=1, o_OWNER=1.
  - A cycle with i_IO_REQ=1 is one transfer. i_IO_ADDR drives both memory addresses, o_MEM_WDATA=i_IO_WDATA and o_MEM_WRITE=i_IO_WRITE.
  - At the clock edge: capture i_MEM_RDATA into o_IO_RDATA (read transfers only), pulse o_IO_ACK the next cycle, and increment the burst counter.
  - Go to RELEASE when i_IO_REQ=0, or when a transfer brings the counter to MAX_BURST. The limiting transfer still completes and is acked.
- **RELEASE**
  - Lasts one cycle: o_IO_GNT=0, o_IOPAUSE=1, o_MEM_WRITE=0, addresses from CPU.
  - Load the guard counter with CPU_GUARD and go to CPU.
- **Guard counter**: decrements by 1 per clock in CPU state, saturating at 0.
- **Width rules**
  - Burst counter is 8 bits and compared for equality with MAX_BURST.
  - Guard counter is 8 bits.
  - No address arithmetic is done; the CPU applies its offset before the arbiter.

## Timing
- **Reset values**: state CPU, o_IOPAUSE=0, o_IO_GNT=0, o_IO_ACK=0, o_IO_RDATA=0, o_OWNER=0, both counters 0. Memory outputs equal the CPU pass-through.
- **Reset mid-burst**: asynchronous return to the reset values. Pause is released immediately. A pending ack is dropped.
- **Request to grant latency**:
  - 2 cycles if i_CPU_HALTED is already high: 1 cycle to PAUSE_WAIT, 1 to IO.
  - Otherwise 1 cycle plus the wait for i_CPU_HALTED.
- **Ack timing**: o_IO_ACK follows each transfer by exactly 1 cycle. The last ack is asserted during RELEASE.
- **Grant to release**: pause deasserts 1 cycle after o_IO_GNT falls.
- **Simultaneous events**
  - i_IO_REQ falling in the same cycle the counter reaches MAX_BURST gives a single RELEASE.
  - i_IO_REQ high while guard>0 waits in CPU.
  - i_CPU_HALTED falling during IO is ignored.
- o_IO_GNT and o_IOPAUSE are registered; o_MEM_* are combinational from state and inputs.

## Configuration
- **MEM_ARB_BURST_LIMIT_EN defined**: burst is limited to MAX_BURST as described.
- **Not defined**
  - The burst counter is absent and MAX_BURST is ignored.
  - IO is held until i_IO_REQ drops, so the requester can starve the CPU indefinitely.
  - The guard counter still applies.

## Test plan
- Reset with i_IO_REQ=1 and i_CPU_HALTED=1, then release reset: o_IOPAUSE=1 at cycle 1, o_IO_GNT=1 at cycle 2, and before that o_MEM_* equal the CPU inputs.
- Read burst of 3 to addresses 0x0100..0x0102 with memory returning 0xA000+addr: three o_IO_ACK pulses carrying 0xA100, 0xA101, 0xA102, then RELEASE, then pause low.
- Continuous request with MAX_BURST=8 and the macro defined: exactly 8 transfers, then RELEASE, then 4 CPU cycles, then PAUSE_WAIT again. With the macro undefined: 20 consecutive transfers, no release.
- Request while i_CPU_HALTED=0 for 5 cycles: PAUSE_WAIT held with o_IO_GNT=0 and CPU writes passing through; grant 1 cycle after i_CPU_HALTED rises.
- i_IO_REQ dropped during PAUSE_WAIT: RELEASE, then CPU, with no grant and no ack.
- i_RESETn asserted mid-write-burst: o_IOPAUSE, o_IO_GNT, o_IO_ACK and o_MEM_WRITE (with i_CPU_WRITE=0) fall without waiting for a clock edge.
